hazard_forward_unit: RTL and testbench

Stall and forwarding controller for the 5-stage MIPS pipeline. It reads the fields captured by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers: source registers in ID, and destinations and control in EX, MEM and WB. It drives back the register load enables, bubble insertion and ID-stage operand forwarding selects. It also tracks the multi-cycle multiply/divide unit with a busy counter so that HI/LO readers and back-to-back mult/div operations stall correctly.

---
 rtl/pipeline_pkg.sv | 23 ++
 rtl/fwd_select.sv | 29 ++
 rtl/hazard_forward_unit.sv | 146 ++++++++++++++
 tb/tb_hazard_forward_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: forwarding select encodings, mult/div FSM state and
// register-field constants used by the hazard/forwarding logic.
package pipeline_pkg;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned FWD_W    = 2;
    localparam int unsigned MD_CNT_W = 4;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [FWD_W-1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/fwd_select.sv
// Priority selector for one ID operand: EX > MEM > WB > register file.
// Register 0 is never forwarded.
module fwd_select
    import pipeline_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] ex_wd,
    input  logic       ex_we,
    input  logic [4:0] mem_wd,
    input  logic       mem_we,
    input  logic [4:0] wb_wd,
    input  logic       wb_we,
    output logic [1:0] sel_c
);

    always_comb begin
        sel_c = FWD_RF;
        if (src != REG_ZERO) begin
            if (ex_we && (ex_wd == src)) begin
                sel_c = FWD_EX;
            end else if (mem_we && (mem_wd == src)) begin
                sel_c = FWD_MEM;
            end else if (wb_we && (wb_wd == src)) begin
                sel_c = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Stall/forwarding controller for the 5-stage pipeline with a mult/div busy tracker.
// Optional stall performance counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_forward_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_md,
    input  logic             id_uses_hilo,
    input  logic [4:0]       ex_wd,
    input  logic [4:0]       mem_wd,
    input  logic [4:0]       wb_wd,
    input  logic             ex_reg_write,
    input  logic             mem_reg_write,
    input  logic             wb_reg_write,
    input  logic             ex_load,
    output logic             pc_le,
    output logic             ifid_le,
    output logic             idex_nop,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             md_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    if ((MD_LATENCY < 2) || (MD_LATENCY > 15) || (CNT_W == 0)) begin : g_bad_param
        $error("hazard_forward_unit: MD_LATENCY must be 2..15 and CNT_W nonzero");
    end

    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY - 1);

    md_state_e           state_q, state_d;
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;

    logic       load_use_c;
    logic       md_hazard_c;
    logic       stall_c;
    logic [1:0] fwd_a_c;
    logic [1:0] fwd_b_c;

    fwd_select u_fwd_rs (
        .src    (id_rs),
        .ex_wd  (ex_wd),
        .ex_we  (ex_reg_write),
        .mem_wd (mem_wd),
        .mem_we (mem_reg_write),
        .wb_wd  (wb_wd),
        .wb_we  (wb_reg_write),
        .sel_c  (fwd_a_c)
    );

    fwd_select u_fwd_rt (
        .src    (id_rt),
        .ex_wd  (ex_wd),
        .ex_we  (ex_reg_write),
        .mem_wd (mem_wd),
        .mem_we (mem_reg_write),
        .wb_wd  (wb_wd),
        .wb_we  (wb_reg_write),
        .sel_c  (fwd_b_c)
    );

    assign md_busy = (state_q == MD_BUSY);

    // Reset forces a clean "run, no forwarding" view regardless of ID/EX contents.
    always_comb begin
        load_use_c  = ex_load && ex_reg_write && (ex_wd != REG_ZERO) &&
                      ((id_uses_rs && (ex_wd == id_rs)) || (id_uses_rt && (ex_wd == id_rt)));
        md_hazard_c = md_busy && (id_uses_hilo || id_is_md);
        stall_c     = !reset && (load_use_c || md_hazard_c);
        pc_le       = !stall_c;
        ifid_le     = !stall_c;
        idex_nop    = stall_c;
        fwd_a       = reset ? 2'(FWD_RF) : fwd_a_c;
        fwd_b       = reset ? 2'(FWD_RF) : fwd_b_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // A stalled mult/div does not issue; the busy count runs down even while stalled.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            RUN: begin
                if (id_is_md && !stall_c) begin
                    state_d  = MD_BUSY;
                    md_cnt_d = MD_LOAD;
                end
            end
            MD_BUSY: begin
                if (md_cnt_q <= MD_CNT_W'(1)) begin
                    state_d  = RUN;
                    md_cnt_d = '0;
                end else begin
                    md_cnt_d = md_cnt_q - MD_CNT_W'(1);
                end
            end
            default: begin
                state_d  = RUN;
                md_cnt_d = '0;
            end
        endcase
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Saturating count of stalled cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: driver queues expected outputs,
// a negedge monitor pops and compares. Counter checks need HAZARD_PERF_CNT_EN.
module tb_hazard_forward_unit;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_wd, mem_wd, wb_wd;
    logic       id_uses_rs, id_uses_rt, id_is_md, id_uses_hilo;
    logic       ex_reg_write, mem_reg_write, wb_reg_write, ex_load;
    logic       pc_le, ifid_le, idex_nop, md_busy;
    logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [2:0]  stall_cnt_s;
    logic        s_pc_le, s_ifid_le, s_idex_nop, s_md_busy;
    logic [1:0]  s_fwd_a, s_fwd_b;
`endif

    typedef struct {
        string       name;
        logic        stall;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        busy;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    hazard_forward_unit #(.MD_LATENCY(4), .CNT_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .id_is_md      (id_is_md),
        .id_uses_hilo  (id_uses_hilo),
        .ex_wd         (ex_wd),
        .mem_wd        (mem_wd),
        .wb_wd         (wb_wd),
        .ex_reg_write  (ex_reg_write),
        .mem_reg_write (mem_reg_write),
        .wb_reg_write  (wb_reg_write),
        .ex_load       (ex_load),
        .pc_le         (pc_le),
        .ifid_le       (ifid_le),
        .idex_nop      (idex_nop),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .md_busy       (md_busy)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

`ifdef HAZARD_PERF_CNT_EN
    // Narrow-counter copy to reach saturation quickly.
    hazard_forward_unit #(.MD_LATENCY(4), .CNT_W(3)) dut_s (
        .clk           (clk),
        .reset         (reset),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .id_is_md      (id_is_md),
        .id_uses_hilo  (id_uses_hilo),
        .ex_wd         (ex_wd),
        .mem_wd        (mem_wd),
        .wb_wd         (wb_wd),
        .ex_reg_write  (ex_reg_write),
        .mem_reg_write (mem_reg_write),
        .wb_reg_write  (wb_reg_write),
        .ex_load       (ex_load),
        .pc_le         (s_pc_le),
        .ifid_le       (s_ifid_le),
        .idex_nop      (s_idex_nop),
        .fwd_a         (s_fwd_a),
        .fwd_b         (s_fwd_b),
        .md_busy       (s_md_busy),
        .stall_cnt     (stall_cnt_s)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clr();
        id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0;
        id_is_md = 0; id_uses_hilo = 0;
        ex_wd = '0; mem_wd = '0; wb_wd = '0;
        ex_reg_write = 0; mem_reg_write = 0; wb_reg_write = 0; ex_load = 0;
    endtask

    task automatic push(input string name, input logic s, input logic [1:0] fa,
                        input logic [1:0] fb, input logic b, input int cnt);
        exp_t e;
        e.name = name; e.stall = s; e.fa = fa; e.fb = fb; e.busy = b; e.cnt = 32'(cnt);
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use_r9();
        ex_load = 1; ex_wd = 5'd9; ex_reg_write = 1; id_rs = 5'd9; id_uses_rs = 1;
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [7:0] got, want;
            e = exp_q.pop_front();
            got  = {pc_le, ifid_le, idex_nop, fwd_a, fwd_b, md_busy};
            want = {!e.stall, !e.stall, e.stall, e.fa, e.fb, e.busy};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL %s: got pc_le=%b ifid_le=%b idex_nop=%b fwd_a=%0d fwd_b=%0d md_busy=%b, want %b %b %b %0d %0d %b",
                         e.name, pc_le, ifid_le, idex_nop, fwd_a, fwd_b, md_busy,
                         !e.stall, !e.stall, e.stall, e.fa, e.fb, e.busy);
            end
`ifdef HAZARD_PERF_CNT_EN
            n_cmp++;
            if (stall_cnt !== e.cnt) begin
                n_bad++;
                $display("FAIL %s stall_cnt: got %0d want %0d", e.name, stall_cnt, e.cnt);
            end
            n_cmp++;
            if (stall_cnt_s !== ((e.cnt > 7) ? 3'd7 : 3'(e.cnt))) begin
                n_bad++;
                $display("FAIL %s stall_cnt_sat: got %0d want %0d", e.name, stall_cnt_s,
                         (e.cnt > 7) ? 7 : e.cnt);
            end
`endif
        end
    end

    initial begin
        reset = 1;
        clr();
        load_use_r9();
        step(); push("reset_gate", 0, 0, 0, 0, 0);
        step(); reset = 0; clr(); push("idle", 0, 0, 0, 0, 0);
        step(); clr(); ex_wd = 5; ex_reg_write = 1; id_rs = 5; id_uses_rs = 1;
                push("ex_fwd", 0, 1, 0, 0, 0);
        step(); clr(); mem_wd = 7; wb_wd = 7; mem_reg_write = 1; wb_reg_write = 1;
                id_rt = 7; id_uses_rt = 1;
                push("mem_over_wb", 0, 0, 2, 0, 0);
        step(); clr(); wb_wd = 7; wb_reg_write = 1; id_rt = 7; id_uses_rt = 1;
                push("wb_only", 0, 0, 3, 0, 0);
        step(); clr(); ex_reg_write = 1; mem_reg_write = 1; wb_reg_write = 1; id_uses_rt = 1;
                push("reg_zero", 0, 0, 0, 0, 0);
        step(); clr(); load_use_r9(); push("load_use", 1, 1, 0, 0, 0);
        step(); clr(); mem_wd = 9; mem_reg_write = 1; id_rs = 9; id_uses_rs = 1;
                push("after_load", 0, 2, 0, 0, 1);
        step(); clr(); load_use_r9(); id_uses_rs = 0; push("load_no_use", 0, 1, 0, 0, 1);
        step(); clr(); ex_load = 1; ex_reg_write = 1; id_uses_rs = 1;
                push("load_r0", 0, 0, 0, 0, 1);
        step(); clr(); id_is_md = 1; push("mult_issue", 0, 0, 0, 0, 1);
        step(); clr(); id_uses_hilo = 1; push("mfhi_busy1", 1, 0, 0, 1, 1);
        step(); push("mfhi_busy2", 1, 0, 0, 1, 2);
        step(); push("mfhi_busy3", 1, 0, 0, 1, 3);
        step(); push("mfhi_issue", 0, 0, 0, 0, 4);
        step(); clr(); id_is_md = 1; push("mult1_issue", 0, 0, 0, 0, 4);
        step(); push("mult2_wait1", 1, 0, 0, 1, 4);
        step(); push("mult2_wait2", 1, 0, 0, 1, 5);
        step(); push("mult2_wait3", 1, 0, 0, 1, 6);
        step(); push("mult2_issue", 0, 0, 0, 0, 7);
        step(); clr(); push("busy_no_hz", 0, 0, 0, 1, 7);
        step(); clr(); load_use_r9(); id_uses_hilo = 1; push("double_hz", 1, 1, 0, 1, 7);
        step(); reset = 1; push("reset_mid_busy", 0, 0, 0, 0, 0);
        step(); reset = 0; clr(); id_uses_hilo = 1; push("no_residual", 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(); clr(); load_use_r9(); push("sat_run", 1, 1, 0, 0, i);
        end
        step(); clr();

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
